// File: rtl/mem_access.sv
// Memory-access pipeline stage: data-bus request FSM, byte-lane steering and the MEM/WB register.
// Optional misalignment trap: define MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  strCtrlM,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic        MemtoRegM,
   input  logic        PCBranchM,
   input  logic        branchM,
   input  logic [31:0] ALUoutM,
   input  logic [31:0] PCplusImmM,
   input  logic [4:0]  rdM,
   input  logic [31:0] r2M,
   output logic        PCSrcM,
   output logic [31:0] PCTargetM,
   output logic        stallM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        RegWriteW,
   output logic        MemtoRegW,
   output logic [4:0]  rdW,
   output logic [31:0] ALUoutW,
   output logic [31:0] ReadDataW,
   output logic        misalignW
);

   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

   function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] be;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = 4'b0011 << {off[1], 1'b0};
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] w;
      case (f3[1:0])
         2'b00:   w = {4{d[7:0]}};
         2'b01:   w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

   function automatic logic [31:0] load_data(input logic [31:0] d, input logic [2:0] f3,
                                              input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'b00:   b = d[7:0];
         2'b01:   b = d[15:8];
         2'b10:   b = d[23:16];
         default: b = d[31:24];
      endcase
      h = off[1] ? d[31:16] : d[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b100:  r = {24'h000000, b};
         3'b101:  r = {16'h0000, h};
         default: r = d;
      endcase
      return r;
   endfunction

   state_t      state_q, state_d;
   logic        mem_op_s, misalign_s, latch_s;
   logic [1:0]  off_s;
   logic        req_we_q, req_rw_q, req_m2r_q;
   logic [31:0] req_addr_q, req_wdata_q, req_alu_q;
   logic [3:0]  req_be_q;
   logic [2:0]  req_f3_q;
   logic [1:0]  req_off_q;
   logic [4:0]  req_rd_q;
   logic        rw_d, m2r_d, mis_d;
   logic [4:0]  rd_d;
   logic [31:0] alu_d, rdata_d;

   assign mem_op_s  = MemWriteM | MemtoRegM;
   assign off_s     = ALUoutM[1:0];
   assign PCSrcM    = PCBranchM & branchM;
   assign PCTargetM = PCplusImmM;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   assign misalign_s = mem_op_s & (((strCtrlM[1:0] == 2'b01) & off_s[0]) |
                                   (strCtrlM[1] & (off_s != 2'b00)));
`else
   assign misalign_s = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next state and bus drive; IDLE is gated by rst so nothing is issued while reset is held
   always_comb begin
      state_d    = state_q;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = 32'h0000_0000;
      dmem_be    = 4'b0000;
      dmem_wdata = 32'h0000_0000;
      stallM     = 1'b0;
      latch_s    = 1'b0;
      case (state_q)
         IDLE: begin
            if (rst && mem_op_s && !misalign_s) begin
               dmem_req   = 1'b1;
               dmem_we    = MemWriteM;
               dmem_addr  = {ALUoutM[31:2], 2'b00};
               dmem_be    = byte_en(strCtrlM, off_s);
               dmem_wdata = store_data(strCtrlM, r2M);
               if (dmem_ack) begin
                  state_d = IDLE;
               end else begin
                  stallM  = 1'b1;
                  latch_s = 1'b1;
                  state_d = BUSY;
               end
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            dmem_req   = 1'b1;
            dmem_we    = req_we_q;
            dmem_addr  = req_addr_q;
            dmem_be    = req_be_q;
            dmem_wdata = req_wdata_q;
            if (dmem_ack) begin
               state_d = IDLE;
            end else begin
               stallM  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Request registers hold the outstanding transaction stable while BUSY
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_we_q    <= 1'b0;
         req_addr_q  <= 32'h0000_0000;
         req_be_q    <= 4'b0000;
         req_wdata_q <= 32'h0000_0000;
         req_f3_q    <= 3'b000;
         req_off_q   <= 2'b00;
         req_rd_q    <= 5'd0;
         req_rw_q    <= 1'b0;
         req_m2r_q   <= 1'b0;
         req_alu_q   <= 32'h0000_0000;
      end else if (latch_s) begin
         req_we_q    <= MemWriteM;
         req_addr_q  <= {ALUoutM[31:2], 2'b00};
         req_be_q    <= byte_en(strCtrlM, off_s);
         req_wdata_q <= store_data(strCtrlM, r2M);
         req_f3_q    <= strCtrlM;
         req_off_q   <= off_s;
         req_rd_q    <= rdM;
         req_rw_q    <= RegWriteM;
         req_m2r_q   <= MemtoRegM;
         req_alu_q   <= ALUoutM;
      end
   end

   // MEM/WB next value: bubble on stall, request registers on BUSY completion, else live inputs
   always_comb begin
      rw_d    = RegWriteW;
      m2r_d   = MemtoRegW;
      rd_d    = rdW;
      alu_d   = ALUoutW;
      rdata_d = ReadDataW;
      mis_d   = 1'b0;
      if (stallM) begin
         rw_d  = 1'b0;
         m2r_d = 1'b0;
      end else if (state_q == BUSY) begin
         rw_d    = req_rw_q;
         m2r_d   = req_m2r_q;
         rd_d    = req_rd_q;
         alu_d   = req_alu_q;
         rdata_d = load_data(dmem_rdata, req_f3_q, req_off_q);
      end else if (misalign_s) begin
         rw_d  = 1'b0;
         m2r_d = 1'b0;
         mis_d = 1'b1;
         rd_d  = rdM;
         alu_d = ALUoutM;
      end else begin
         rw_d    = RegWriteM;
         m2r_d   = MemtoRegM;
         rd_d    = rdM;
         alu_d   = ALUoutM;
         rdata_d = load_data(dmem_rdata, strCtrlM, off_s);
      end
   end

   // MEM/WB register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWriteW <= 1'b0;
         MemtoRegW <= 1'b0;
         rdW       <= 5'd0;
         ALUoutW   <= 32'h0000_0000;
         ReadDataW <= 32'h0000_0000;
         misalignW <= 1'b0;
      end else begin
         RegWriteW <= rw_d;
         MemtoRegW <= m2r_d;
         rdW       <= rd_d;
         ALUoutW   <= alu_d;
         ReadDataW <= rdata_d;
         misalignW <= mis_d;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected bus/writeback items, a negedge monitor checks them.
// Build with MEM_ACCESS_MISALIGN_TRAP_EN to exercise the misalignment trap expectations.
module tb_mem_access;
   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  strCtrlM;
   logic        RegWriteM, MemWriteM, MemtoRegM, PCBranchM, branchM;
   logic [31:0] ALUoutM, PCplusImmM, r2M;
   logic [4:0]  rdM;
   logic        PCSrcM, stallM;
   logic [31:0] PCTargetM;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        RegWriteW, MemtoRegW, misalignW;
   logic [4:0]  rdW;
   logic [31:0] ALUoutW, ReadDataW;

   typedef struct {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;} bus_t;
   typedef struct {logic rw; logic m2r; logic mis; logic [4:0] rd; logic [31:0] alu; logic [31:0] rdata;} wb_t;
   bus_t bus_q[$];
   wb_t  wb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   mem_access dut (
      .clk(clk), .rst(rst), .strCtrlM(strCtrlM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
      .MemtoRegM(MemtoRegM), .PCBranchM(PCBranchM), .branchM(branchM), .ALUoutM(ALUoutM),
      .PCplusImmM(PCplusImmM), .rdM(rdM), .r2M(r2M), .PCSrcM(PCSrcM), .PCTargetM(PCTargetM),
      .stallM(stallM), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .rdW(rdW), .ALUoutW(ALUoutW),
      .ReadDataW(ReadDataW), .misalignW(misalignW)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_nop();
      strCtrlM = 3'b000; RegWriteM = 1'b0; MemWriteM = 1'b0; MemtoRegM = 1'b0;
      PCBranchM = 1'b0; branchM = 1'b0; ALUoutM = 32'h0; PCplusImmM = 32'h0;
      rdM = 5'd0; r2M = 32'h0;
   endtask

   task automatic mem(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [4:0] rd);
      set_nop();
      MemWriteM = we; MemtoRegM = ~we; RegWriteM = ~we;
      strCtrlM = f3; ALUoutM = addr; r2M = wd; rdM = rd;
   endtask

   task automatic push_bus(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
      bus_t b;
      b.we = we; b.addr = a; b.be = be; b.wdata = wd;
      bus_q.push_back(b);
   endtask

   task automatic push_wb(input logic rw, input logic m2r, input logic mis, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] rdata);
      wb_t w;
      w.rw = rw; w.m2r = m2r; w.mis = mis; w.rd = rd; w.alu = alu; w.rdata = rdata;
      wb_q.push_back(w);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // Monitor: completed bus transactions and writeback results against the scoreboard
   always @(negedge clk) begin
      if (rst) begin
         if (dmem_req && dmem_ack) begin
            if (bus_q.size() == 0) begin
               chk("bus_unexpected", 32'd1, 32'd0);
            end else begin
               bus_t b;
               b = bus_q.pop_front();
               chk("bus_we", {31'd0, dmem_we}, {31'd0, b.we});
               chk("bus_addr", dmem_addr, b.addr);
               chk("bus_be", {28'd0, dmem_be}, {28'd0, b.be});
               if (b.we) chk("bus_wdata", dmem_wdata, b.wdata);
            end
         end
         if (RegWriteW || misalignW) begin
            if (wb_q.size() == 0) begin
               chk("wb_unexpected", 32'd1, 32'd0);
            end else begin
               wb_t w;
               w = wb_q.pop_front();
               chk("wb_regwrite", {31'd0, RegWriteW}, {31'd0, w.rw});
               chk("wb_memtoreg", {31'd0, MemtoRegW}, {31'd0, w.m2r});
               chk("wb_misalign", {31'd0, misalignW}, {31'd0, w.mis});
               chk("wb_rd", {27'd0, rdW}, {27'd0, w.rd});
               chk("wb_alu", ALUoutW, w.alu);
               if (w.m2r) chk("wb_rdata", ReadDataW, w.rdata);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
      set_nop();
      MemtoRegM = 1'b1; ALUoutM = 32'h10; PCBranchM = 1'b1; branchM = 1'b1; PCplusImmM = 32'h88;
      @(negedge clk);
      chk("rst_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_stall", {31'd0, stallM}, 32'd0);
      chk("rst_regwrite", {31'd0, RegWriteW}, 32'd0);
      chk("rst_readdata", ReadDataW, 32'h0);
      chk("rst_aluout", ALUoutW, 32'h0);
      chk("rst_misalign", {31'd0, misalignW}, 32'd0);
      chk("rst_pcsrc", {31'd0, PCSrcM}, 32'd1);
      chk("rst_pctarget", PCTargetM, 32'h88);
      #2 set_nop(); rst = 1'b1;
      next();

      // SW with same-cycle ack
      mem(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0); dmem_ack = 1'b1;
      push_bus(1'b1, 32'h100, 4'b1111, 32'hDEADBEEF);
      @(negedge clk); chk("sw_stall", {31'd0, stallM}, 32'd0);
      next();

      // ALU op, then LB with ack after three stall cycles
      set_nop(); dmem_ack = 1'b0; RegWriteM = 1'b1; rdM = 5'd3; ALUoutM = 32'h1234;
      push_wb(1'b1, 1'b0, 1'b0, 5'd3, 32'h1234, 32'h0);
      @(negedge clk);
      chk("alu_req", {31'd0, dmem_req}, 32'd0);
      chk("alu_be", {28'd0, dmem_be}, 32'd0);
      chk("alu_we", {31'd0, dmem_we}, 32'd0);
      next();
      mem(1'b0, 3'b000, 32'h203, 32'h0, 5'd5);
      push_bus(1'b0, 32'h200, 4'b1000, 32'h0);
      push_wb(1'b1, 1'b1, 1'b0, 5'd5, 32'h203, 32'hFFFFFF80);
      @(negedge clk);
      chk("lb_stall0", {31'd0, stallM}, 32'd1);
      chk("lb_req0", {31'd0, dmem_req}, 32'd1);
      for (int i = 1; i < 4; i++) begin
         next();
         ALUoutM = 32'h0FFF;
         if (i == 3) begin dmem_ack = 1'b1; dmem_rdata = 32'h80FF0000; end
         @(negedge clk);
         chk("lb_stall", {31'd0, stallM}, (i == 3) ? 32'd0 : 32'd1);
         chk("lb_addr_stable", dmem_addr, 32'h200);
         chk("lb_be_stable", {28'd0, dmem_be}, 32'h8);
         chk("lb_bubble", {31'd0, RegWriteW}, 32'd0);
      end
      next();

      // LHU, LH, LBU, SB, SH with immediate ack
      mem(1'b0, 3'b101, 32'h202, 32'h0, 5'd7); dmem_ack = 1'b1; dmem_rdata = 32'h80011234;
      push_bus(1'b0, 32'h200, 4'b1100, 32'h0);
      push_wb(1'b1, 1'b1, 1'b0, 5'd7, 32'h202, 32'h00008001);
      @(negedge clk); chk("lhu_stall", {31'd0, stallM}, 32'd0);
      next();
      mem(1'b0, 3'b001, 32'h300, 32'h0, 5'd8); dmem_rdata = 32'h00008765;
      push_bus(1'b0, 32'h300, 4'b0011, 32'h0);
      push_wb(1'b1, 1'b1, 1'b0, 5'd8, 32'h300, 32'hFFFF8765);
      next();
      mem(1'b0, 3'b100, 32'h301, 32'h0, 5'd9); dmem_rdata = 32'h00009900;
      push_bus(1'b0, 32'h300, 4'b0010, 32'h0);
      push_wb(1'b1, 1'b1, 1'b0, 5'd9, 32'h301, 32'h00000099);
      next();
      mem(1'b1, 3'b000, 32'h402, 32'h123456AB, 5'd0);
      push_bus(1'b1, 32'h400, 4'b0100, 32'hABABABAB);
      next();
      mem(1'b1, 3'b001, 32'h402, 32'h0000CAFE, 5'd0);
      push_bus(1'b1, 32'h400, 4'b1100, 32'hCAFECAFE);
      next();

      // Branch resolution, no bus activity
      set_nop(); dmem_ack = 1'b0; dmem_rdata = 32'h0;
      PCBranchM = 1'b1; branchM = 1'b1; PCplusImmM = 32'h40;
      @(negedge clk);
      chk("br_pcsrc", {31'd0, PCSrcM}, 32'd1);
      chk("br_target", PCTargetM, 32'h40);
      chk("br_req", {31'd0, dmem_req}, 32'd0);
      chk("br_be", {28'd0, dmem_be}, 32'd0);
      chk("br_stall", {31'd0, stallM}, 32'd0);
      next();
      branchM = 1'b0;
      @(negedge clk); chk("br_not_taken", {31'd0, PCSrcM}, 32'd0);
      next();

      // Misaligned LW
      mem(1'b0, 3'b010, 32'h101, 32'h0, 5'd10);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      push_wb(1'b0, 1'b0, 1'b1, 5'd10, 32'h101, 32'h0);
      @(negedge clk);
      chk("mis_req", {31'd0, dmem_req}, 32'd0);
      chk("mis_stall", {31'd0, stallM}, 32'd0);
`else
      dmem_ack = 1'b1; dmem_rdata = 32'h11223344;
      push_bus(1'b0, 32'h100, 4'b1111, 32'h0);
      push_wb(1'b1, 1'b1, 1'b0, 5'd10, 32'h101, 32'h11223344);
      @(negedge clk);
      chk("mis_stall", {31'd0, stallM}, 32'd0);
`endif
      next();

      // Reset while BUSY, then a stray ack
      mem(1'b0, 3'b010, 32'h500, 32'h0, 5'd11); dmem_ack = 1'b0; dmem_rdata = 32'h0;
      next();
      @(negedge clk);
      chk("busy_stall", {31'd0, stallM}, 32'd1);
      chk("busy_req", {31'd0, dmem_req}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("rstbusy_req", {31'd0, dmem_req}, 32'd0);
      chk("rstbusy_stall", {31'd0, stallM}, 32'd0);
      chk("rstbusy_regwrite", {31'd0, RegWriteW}, 32'd0);
      set_nop();
      next();
      rst = 1'b1; dmem_ack = 1'b1;
      @(negedge clk);
      chk("stray_req", {31'd0, dmem_req}, 32'd0);
      chk("stray_stall", {31'd0, stallM}, 32'd0);
      next();
      dmem_ack = 1'b0;
      mem(1'b0, 3'b010, 32'h600, 32'h0, 5'd12);
      push_bus(1'b0, 32'h600, 4'b1111, 32'h0);
      push_wb(1'b1, 1'b1, 1'b0, 5'd12, 32'h600, 32'hA5A5A5A5);
      @(negedge clk);
      chk("post_rst_addr", dmem_addr, 32'h600);
      chk("post_rst_stall", {31'd0, stallM}, 32'd1);
      next();
      dmem_ack = 1'b1; dmem_rdata = 32'hA5A5A5A5;
      next();
      set_nop(); dmem_ack = 1'b0; dmem_rdata = 32'h0;
      next();
      next();
      chk("bus_queue_empty", bus_q.size(), 32'd0);
      chk("wb_queue_empty", wb_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have execute-side inputs: strCtrlM 3 (funct3); RegWriteM, MemWriteM, MemtoRegM, PCBranchM, branchM 1 each; ALUoutM 32 (address/result); PCplusImmM 32; rdM 5; r2M 32 (store data).
REQ-003 SHALL have outputs to fetch/hazard: PCSrcM 1; PCTargetM 32; stallM 1 (hold upstream stages).
REQ-004 SHALL have data-bus outputs dmem_req 1, dmem_we 1, dmem_addr 32, dmem_be 4, dmem_wdata 32, and inputs dmem_ack 1, dmem_rdata 32.
REQ-005 SHALL have writeback outputs: RegWriteW 1, MemtoRegW 1, rdW 5, ALUoutW 32, ReadDataW 32, misalignW 1.

Function
REQ-006 SHALL treat memory op = MemWriteM | MemtoRegM; store if MemWriteM, else load.
REQ-007 SHALL drive PCSrcM = PCBranchM & branchM and PCTargetM = PCplusImmM, combinational.
REQ-008 SHALL drive dmem_addr = {ALUoutM[31:2],2'b00}, byte offset = ALUoutM[1:0].
REQ-009 SHALL generate dmem_be: byte (strCtrl[1:0]=00) 4'b0001<<off; half (01) 4'b0011<<{off[1],1'b0}; word (10) 4'b1111.
REQ-010 SHALL replicate store data: byte {4{r2M[7:0]}}, half {2{r2M[15:0]}}, word r2M.
REQ-011 SHALL extract loads from dmem_rdata by lane: LB/LH sign-extend, LBU(100)/LHU(101) zero-extend, LW unchanged.
REQ-012 SHALL have FSM states IDLE, BUSY; reset state IDLE.
REQ-013 IDLE, memory op present: dmem_req=1 combinationally from current inputs; dmem_ack same cycle -> op completes, stallM=0, stay IDLE.
REQ-014 IDLE, memory op, no ack: latch addr/be/wdata/we/strCtrl/offset/rd/RegWrite/MemtoReg/ALUout into request registers, stallM=1, go BUSY.
REQ-015 BUSY: dmem_req=1 with all bus outputs from request registers (stable), stallM=1 until ack; ack -> stallM=0 that cycle, go IDLE.
REQ-016 SHALL drive dmem_req=0, dmem_we=0, dmem_be=0 whenever no request is issued.
REQ-017 SHALL load the MEM/WB register every clock: completing op or non-memory op -> capture control, rdW, ALUoutW, extracted ReadDataW; stall cycle (stallM=1) -> bubble, RegWriteW=0, MemtoRegW=0, other fields hold.
REQ-018 Load-data latency: ReadDataW valid exactly one cycle after the ack cycle.
REQ-019 SHALL ignore dmem_ack while no request is outstanding.
REQ-020 SHALL not issue a new request in the ack cycle of BUSY; next request earliest the following cycle.

Reset
REQ-021 On rst low, asynchronously: state IDLE; request registers 0; RegWriteW=0, MemtoRegW=0, rdW=0, ALUoutW=0, ReadDataW=0, misalignW=0.
REQ-022 Reset mid-operation (BUSY) SHALL abandon the request; dmem_req=0 during and after reset until a new memory op.
REQ-023 Combinational outputs (PCSrcM, PCTargetM) SHALL follow inputs during reset; stallM=0 during reset.

Configuration
REQ-024 Macro MEM_ACCESS_MISALIGN_TRAP_EN SHALL control misalignment handling.
REQ-025 Defined: half at off[0]=1 or word at off!=0 SHALL issue no bus request, no stall; next cycle misalignW=1, RegWriteW=0, MemtoRegW=0, rdW/ALUoutW captured.
REQ-026 Undefined: misalignW tied 0; half uses off[1] only, word uses lane 0 (low address bits ignored); request issued normally.

Verification
REQ-027 SW r2M=0xDEADBEEF, ALUoutM=0x100, ack same cycle -> dmem_we=1, addr=0x100, be=1111, wdata=0xDEADBEEF, stallM=0.
REQ-028 LB ALUoutM=0x203, dmem_rdata=0x80FF_0000, ack after 3 cycles -> stallM=1 for 3 cycles, bus stable, RegWriteW=0 during stall, then ReadDataW=0xFFFFFF80, RegWriteW=1.
REQ-029 LHU ALUoutM=0x202, rdata=0x8001_1234, immediate ack -> be=1100, ReadDataW=0x00008001 next cycle.
REQ-030 PCBranchM=1, branchM=1, PCplusImmM=0x40 -> PCSrcM=1, PCTargetM=0x40, no bus request.
REQ-031 rst low while BUSY -> dmem_req=0, stallM=0, RegWriteW=0, FSM IDLE; after release, stray dmem_ack ignored.
REQ-032 With MEM_ACCESS_MISALIGN_TRAP_EN, LW ALUoutM=0x101 -> dmem_req=0, misalignW=1 next cycle, RegWriteW=0; without macro -> request to 0x100, be=1111.
